// File: rtl/card_dealer.sv
// Single-deck card source: deals each of 52 cards at most once per shuffle.
// Define DEALER_LFSR_EN for a pseudo-random start probe; otherwise deal order is fixed.
module card_dealer #(
   parameter logic [5:0] SEED = 6'h2D
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_shuffle,
   input  logic       i_draw,
   output logic       o_card_valid,
   output logic [1:0] o_card_suit,
   output logic [3:0] o_card_rank,
   output logic [3:0] o_card_value,
   output logic       o_flag,
   output logic       o_busy,
   output logic       o_empty,
   output logic [5:0] o_cards_left
);

   typedef enum logic {S_IDLE, S_SEEK} state_t;

   state_t      r_state;
   logic [51:0] r_used;
   logic [1:0]  r_psuit;
   logic [3:0]  r_prank;
   logic [5:0]  r_cards_left;
   logic        r_card_valid;
   logic [1:0]  r_card_suit;
   logic [3:0]  r_card_rank;
   logic [3:0]  r_card_value;
   logic        r_flag;
   logic        r_busy;

   logic [5:0]  w_idx;
   logic [3:0]  w_rank;
   logic [3:0]  w_value;
   logic [1:0]  w_load_suit;
   logic [3:0]  w_load_rank;

`ifdef DEALER_LFSR_EN
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [5:0] LFSR_INIT = (SEED == 6'h00) ? 6'h01 : SEED;
   logic [5:0] r_lfsr;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_lfsr <= LFSR_INIT;
      else       r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
   end

   assign w_load_suit = r_lfsr[5:4];
   assign w_load_rank = (r_lfsr[3:0] >= 4'd13) ? (r_lfsr[3:0] - 4'd13) : r_lfsr[3:0];
`else
   logic w_unused_seed;
   assign w_unused_seed = ^SEED;
   assign w_load_suit   = 2'd0;
   assign w_load_rank   = 4'd0;
`endif

   assign w_idx   = 6'(r_psuit) * 6'd13 + 6'(r_prank);
   assign w_rank  = r_prank + 4'd1;
   assign w_value = (w_rank == 4'd1) ? 4'd11 : ((w_rank >= 4'd10) ? 4'd10 : w_rank);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_used       <= '0;
         r_psuit      <= 2'd0;
         r_prank      <= 4'd0;
         r_cards_left <= 6'd52;
         r_card_valid <= 1'b0;
         r_card_suit  <= 2'd0;
         r_card_rank  <= 4'd0;
         r_card_value <= 4'd0;
         r_flag       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_card_valid <= 1'b0;
         if (i_shuffle) begin
            // Card outputs and flag deliberately keep the last dealt card.
            r_used       <= '0;
            r_cards_left <= 6'd52;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_draw && (r_cards_left != 6'd0)) begin
                     r_psuit <= w_load_suit;
                     r_prank <= w_load_rank;
                     r_state <= S_SEEK;
                     r_busy  <= 1'b1;
                  end
               end
               S_SEEK: begin
                  if (!r_used[w_idx]) begin
                     r_used[w_idx] <= 1'b1;
                     r_cards_left  <= r_cards_left - 6'd1;
                     r_card_suit   <= r_psuit;
                     r_card_rank   <= w_rank;
                     r_card_value  <= w_value;
                     r_flag        <= ~r_flag;
                     r_card_valid  <= 1'b1;
                     r_state       <= S_IDLE;
                     r_busy        <= 1'b0;
                  end else if (r_prank == 4'd12) begin
                     r_prank <= 4'd0;
                     r_psuit <= r_psuit + 2'd1;
                  end else begin
                     r_prank <= r_prank + 4'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_card_valid = r_card_valid;
   assign o_card_suit  = r_card_suit;
   assign o_card_rank  = r_card_rank;
   assign o_card_value = r_card_value;
   assign o_flag       = r_flag;
   assign o_busy       = r_busy;
   assign o_empty      = (r_cards_left == 6'd0);
   assign o_cards_left = r_cards_left;

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer (fixed order by default, LFSR order if DEALER_LFSR_EN).
module tb_card_dealer;

   logic       clk = 1'b0;
   logic       rst;
   logic       shuffle;
   logic       draw;
   logic       card_valid;
   logic [1:0] card_suit;
   logic [3:0] card_rank;
   logic [3:0] card_value;
   logic       flag;
   logic       busy;
   logic       empty;
   logic [5:0] cards_left;

   int errors = 0;
   int checks = 0;

   // Blackjack values for ranks 1..13
   int vals[13] = '{11, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10};

   card_dealer #(.SEED(6'h2D)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_shuffle    (shuffle),
      .i_draw       (draw),
      .o_card_valid (card_valid),
      .o_card_suit  (card_suit),
      .o_card_rank  (card_rank),
      .o_card_value (card_value),
      .o_flag       (flag),
      .o_busy       (busy),
      .o_empty      (empty),
      .o_cards_left (cards_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_valid"}, 32'(card_valid), 0);
      check({pfx, "_suit"},  32'(card_suit),  0);
      check({pfx, "_rank"},  32'(card_rank),  0);
      check({pfx, "_value"}, 32'(card_value), 0);
      check({pfx, "_flag"},  32'(flag),       0);
      check({pfx, "_busy"},  32'(busy),       0);
      check({pfx, "_empty"}, 32'(empty),      0);
      check({pfx, "_left"},  32'(cards_left), 52);
   endtask

   // One-cycle draw pulse, then wait (bounded) for the strobe; lat counts edges from the draw sample.
   task automatic do_draw(output int lat);
      draw = 1'b1;
      tick();
      draw = 1'b0;
      lat = 1;
      check("busy_seek", 32'(busy), 1);
      while (!card_valid && lat < 60) begin
         tick();
         lat++;
      end
      check("valid_seen", 32'(card_valid), 1);
   endtask

   initial begin
      int lat;
      int nv;
      int bs;
      rst = 1'b1; shuffle = 1'b0; draw = 1'b0;
      repeat (3) tick();
      check_reset_vals("rst");
      rst = 1'b0;

`ifdef DEALER_LFSR_EN
      begin
         int seq0[52];
         int seq1[52];
         for (int run = 0; run < 2; run++) begin
            logic [51:0] seen;
            int dups;
            int sum;
            int diffs;
            int idx;
            seen = '0; dups = 0; sum = 0; diffs = 0;
            if (run == 1) begin
               rst = 1'b1;
               repeat (3) tick();
               rst = 1'b0;
            end
            for (int k = 0; k < 52; k++) begin
               do_draw(lat);
               idx = int'(card_suit) * 13 + int'(card_rank) - 1;
               if (idx < 0 || idx > 51 || seen[idx]) dups++;
               else seen[idx] = 1'b1;
               sum += int'(card_value);
               if (run == 0) seq0[k] = idx;
               else          seq1[k] = idx;
            end
            check("lfsr_dups", dups, 0);
            check("lfsr_sum", sum, 380);
            check("lfsr_left", 32'(cards_left), 0);
            if (run == 1) begin
               for (int k = 0; k < 52; k++) if (seq0[k] != seq1[k]) diffs++;
               check("lfsr_repeat", diffs, 0);
            end
         end
      end
`else
      for (int k = 1; k <= 13; k++) begin
         do_draw(lat);
         check("s0_lat",   lat, k + 1);
         check("s0_suit",  32'(card_suit), 0);
         check("s0_rank",  32'(card_rank), k);
         check("s0_value", 32'(card_value), vals[k-1]);
         check("s0_flag",  32'(flag), k % 2);
         check("s0_left",  32'(cards_left), 52 - k);
         check("s0_busy",  32'(busy), 0);
      end

      for (int k = 14; k <= 19; k++) begin
         do_draw(lat);
         check("s1_rank", 32'(card_rank), ((k - 1) % 13) + 1);
      end

      // 20th draw with a second draw pulse inside the SEEK
      draw = 1'b1;
      tick();
      draw = 1'b0;
      tick();
      draw = 1'b1;
      tick();
      draw = 1'b0;
      nv = 0;
      repeat (40) begin
         tick();
         if (card_valid) nv++;
      end
      check("busy_draw_strobes", nv, 1);
      check("busy_draw_suit",  32'(card_suit), 1);
      check("busy_draw_rank",  32'(card_rank), 7);
      check("busy_draw_value", 32'(card_value), 7);
      check("busy_draw_left",  32'(cards_left), 32);

      for (int k = 21; k <= 52; k++) begin
         do_draw(lat);
         check("deck_suit",  32'(card_suit), (k - 1) / 13);
         check("deck_rank",  32'(card_rank), ((k - 1) % 13) + 1);
         check("deck_value", 32'(card_value), vals[(k - 1) % 13]);
         check("deck_empty", 32'(empty), (k == 52) ? 1 : 0);
      end
      check("deck_left", 32'(cards_left), 0);

      draw = 1'b1;
      tick();
      draw = 1'b0;
      nv = 0; bs = 0;
      repeat (5) begin
         if (card_valid) nv++;
         if (busy) bs = 1;
         tick();
      end
      check("empty_draw_strobes", nv, 0);
      check("empty_draw_busy", bs, 0);

      shuffle = 1'b1;
      tick();
      shuffle = 1'b0;
      check("shuf_left",  32'(cards_left), 52);
      check("shuf_empty", 32'(empty), 0);
      check("shuf_flag",  32'(flag), 0);
      check("shuf_rank",  32'(card_rank), 13);

      do_draw(lat);
      check("post_shuf_lat",  lat, 2);
      check("post_shuf_suit", 32'(card_suit), 0);
      check("post_shuf_rank", 32'(card_rank), 1);
      check("post_shuf_flag", 32'(flag), 1);

      // shuffle lands on the 2nd SEEK cycle, when the deal would otherwise register
      draw = 1'b1;
      tick();
      draw = 1'b0;
      tick();
      shuffle = 1'b1;
      tick();
      shuffle = 1'b0;
      check("abort_valid", 32'(card_valid), 0);
      check("abort_busy",  32'(busy), 0);
      check("abort_left",  32'(cards_left), 52);
      check("abort_rank",  32'(card_rank), 1);
      check("abort_value", 32'(card_value), 11);
      check("abort_flag",  32'(flag), 1);
      nv = 0;
      repeat (4) begin
         tick();
         if (card_valid) nv++;
      end
      check("abort_strobes", nv, 0);

      do_draw(lat);
      check("pre_rst_rank", 32'(card_rank), 1);
      draw = 1'b1;
      tick();
      draw = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("abort_rst");
      nv = 0;
      repeat (4) begin
         tick();
         if (card_valid) nv++;
      end
      check("abort_rst_strobes", nv, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
# card_dealer

Card source answering draw requests from the blackjack controller. Holds one 52-card deck, deals each card at most once per shuffle, and returns suit, rank, and blackjack point value with a one-cycle valid strobe and a toggling flag. The controller asks for a card on deal or hit. This block draws it and reports it.

## Interface
- `SEED`, default 6'h2D: LFSR reset value. A value of 0 is forced to 6'h01.
- `clk`, input, 1 bit: system clock. All logic updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `shuffle`, input, 1 bit: return all 52 cards to the deck. Sampled each cycle.
- `draw`, input, 1 bit: request one card. Sampled only in IDLE.
- `card_valid`, output, 1 bit: one-cycle strobe. Card outputs are new on this cycle.
- `card_suit`, output, 2 bits: suit 0..3 of the last dealt card.
- `card_rank`, output, 4 bits: rank 1..13 of the last dealt card (1 = ace, 11..13 = J/Q/K).
- `card_value`, output, 4 bits: blackjack value. Ace = 11, 2..10 = face value, J/Q/K = 10.
- `flag`, output, 1 bit: toggles on every dealt card.
- `busy`, output, 1 bit: high while in SEEK.
- `empty`, output, 1 bit: high when `cards_left` == 0.
- `cards_left`, output, 6 bits: undealt cards remaining, 0..52.

## Operation
- **State:**
  - 52-bit used mask, one bit per card. Index = suit*13 + (rank-1).
  - Probe pointer: `psuit` (2 bits) and `prank` (0..12).
  - 6-bit Fibonacci LFSR, taps x^6+x^5+1, advances every cycle.
- **FSM states:**
  - IDLE: `draw` & !`empty` & !`shuffle` → load pointer, go to SEEK.
  - SEEK: if used[pointer] == 0, deal that card and go to IDLE. Otherwise step the pointer: `prank`++, and at 12 wrap to 0 with `psuit`++ (3 wraps to 0).
- **Dealing a card:**
  - Register suit, rank and value.
  - Set the mask bit, decrement `cards_left`, toggle `flag`, pulse `card_valid`.
- **Pointer load:**
  - With `DEALER_LFSR_EN` (see Configuration): `psuit` = lfsr[5:4]; `prank` = lfsr[3:0], minus 13 if ≥ 13.
- **Shuffle** has priority over everything except reset:
  - Clears the mask, sets `cards_left` = 52, forces IDLE.
  - A SEEK in progress is aborted with no `card_valid`.
  - Card outputs and `flag` hold their values.
- **Ignored requests:** `draw` while `busy`, or while `empty` with no `shuffle`. No state change.
- **Reset:**
  - `card_valid`, `card_suit`, `card_rank`, `card_value`, `flag`, `busy` = 0.
  - `empty` = 0, `cards_left` = 52, mask cleared, LFSR = `SEED`, FSM = IDLE.
  - Reset mid-SEEK aborts the draw with no strobe.

## Timing
- `draw` is sampled at edge t0 in IDLE; SEEK begins.
- Each SEEK cycle probes one card.
- If the first probe is free, the deal registers at edge t0+1. `card_valid` is high for the cycle after that edge.
- Latency: minimum 2 edges from draw sample to `card_valid`. Maximum 53 edges (51 used cards skipped).
- `busy` is high from edge t0 through the deal edge, and low in the `card_valid` cycle.
- A new `draw` may be sampled in the `card_valid` cycle.
- `empty` rises in the same cycle as the `card_valid` of the 52nd card.
- The mask update and pointer read never conflict, because only one card is dealt per SEEK.

## Configuration
- `DEALER_LFSR_EN` defined:
  - Start probe position comes from the LFSR as above, giving a pseudo-random deal order.
- `DEALER_LFSR_EN` undefined:
  - The LFSR is not instantiated and `SEED` is unused.
  - The pointer loads suit 0, rank 0 on every draw.
  - Deal order is fixed: suit 0 ranks 1..13, then suit 1, and so on.

## Test plan
All scenarios except the last run without `DEALER_LFSR_EN`.
- **First draw after reset:** `rst` for 3 cycles, then `draw` for 1 cycle → `card_valid` 2 edges later. Expect suit 0, rank 1, value 11, `flag` = 1, `cards_left` = 51.
- **First suit:** 13 back-to-back draws → ranks 1..13 with values 11,2,3,4,5,6,7,8,9,10,10,10,10. Latency of the k-th draw is k+1 edges. `flag` toggles every card.
- **Deck exhaustion:** deal 52 cards, then `draw` → `empty` = 1 with the 52nd strobe. No `card_valid`, `busy` stays 0. Then `shuffle` → `cards_left` = 52, `empty` = 0. The next draw returns suit 0, rank 1.
- **Draw while busy:** during the 20th draw's SEEK, pulse `draw` again → exactly one `card_valid` (suit 1, rank 7, value 7). `cards_left` = 32.
- **Abort mid-SEEK:** `shuffle` on the 2nd SEEK cycle of a draw → no strobe, `cards_left` = 52, outputs and `flag` unchanged. Repeat with `rst` instead → all outputs at reset values.
- **With `DEALER_LFSR_EN`, SEED = 6'h2D:** 52 draws → 52 strobes, all (suit, rank) pairs distinct. Sum of `card_value` = 380. Two runs from reset give identical sequences.
